// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier datapath:
// controller state encoding, legal digit sizes and a constant log2 helper.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned STEP_RADIX2 = 1;
  localparam int unsigned STEP_RADIX4 = 2;

  function automatic bit step_legal(input int unsigned step);
    return (step == STEP_RADIX2) || (step == STEP_RADIX4);
  endfunction

  // Smallest r with 2**r >= v; usable in constant expressions.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/operand_shift_reg_if.sv
// Load handshake and controller-side digit stream of the operand register.
interface operand_shift_reg_if
  import mult_pkg::*;
#(
  parameter int unsigned MX_W = 16,
  parameter int unsigned MY_W = 9,
  parameter int unsigned STEP = 1
);
  localparam int unsigned NDIG  = (MY_W + STEP - 1) / STEP;
  localparam int unsigned CNT_W = clog2_f(NDIG + 1);

  logic              in_valid;
  logic              in_ready;
  logic [MX_W-1:0]   in_mx;
  logic [MY_W-1:0]   in_my;
  logic              in_signed;
  logic              sft_my;
  logic              abort;
  logic              out_ack;
  logic [MX_W-1:0]   mx;
  logic [STEP-1:0]   my_digit;
  logic              my_last;
  logic              my_zero;
  logic [CNT_W-1:0]  dig_left;
  logic              done;

  modport master (
    output in_valid, in_mx, in_my, in_signed, sft_my, abort, out_ack,
    input  in_ready, mx, my_digit, my_last, my_zero, dig_left, done
  );

  modport slave (
    input  in_valid, in_mx, in_my, in_signed, sft_my, abort, out_ack,
    output in_ready, mx, my_digit, my_last, my_zero, dig_left, done
  );

endinterface

// File: rtl/digit_counter.sv
// Remaining-digit counter: loads NDIG, counts down on enable, clear has priority.
module digit_counter #(
  parameter int unsigned NDIG  = 9,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(NDIG);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));
  assign zero = (cnt == '0);

endmodule

// File: rtl/operand_shift_reg.sv
// Operand register for the sequential multiplier: holds MX, streams MY out
// STEP bits per shift and tracks the remaining digit count.
module operand_shift_reg
  import mult_pkg::*;
#(
  parameter int unsigned MX_W = 16,
  parameter int unsigned MY_W = 9,
  parameter int unsigned STEP = 1
) (
  input logic               clk,
  input logic               rst_n,
  operand_shift_reg_if.slave bus
);

  localparam int unsigned NDIG  = (MY_W + STEP - 1) / STEP;
  localparam int unsigned MYP   = NDIG * STEP;
  localparam int unsigned CNT_W = clog2_f(NDIG + 1);

  generate
    if (!step_legal(STEP)) begin : g_bad_step
      $fatal(1, "operand_shift_reg: STEP must be 1 or 2");
    end
  endgenerate

  state_t                   state;
  logic [MX_W-1:0]          mx_q;
  logic [MYP-1:0]           my_q;
  logic                     signed_q;
  logic [MYP-1:0]           my_ld;
  logic [MYP-1:0]           my_sh;
  logic signed [MY_W-1:0]   in_my_s;
  logic signed [MYP-1:0]    my_s;
  logic                     load;
  logic                     shift;
  logic [CNT_W-1:0]         cnt;
  logic                     cnt_last;
  logic                     cnt_zero;

  assign in_my_s = bus.in_my;
  assign my_s    = my_q;

  // The pad bits above MY_W come from the extension, so a padded final digit is well formed.
  always_comb begin
    my_ld = MYP'(bus.in_my);
    if (bus.in_signed) my_ld = MYP'(in_my_s);
    my_sh = my_q >> STEP;
    if (signed_q) my_sh = my_s >>> STEP;
  end

  assign load  = (state == ST_IDLE)  && bus.in_valid && !bus.abort;
  assign shift = (state == ST_SHIFT) && bus.sft_my   && !bus.abort && !cnt_zero;

  digit_counter #(
    .NDIG  (NDIG),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.abort),
    .load  (load),
    .dec   (shift),
    .cnt   (cnt),
    .last  (cnt_last),
    .zero  (cnt_zero)
  );

  // Controller FSM plus operand registers; abort wins over every other request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mx_q     <= '0;
      my_q     <= '0;
      signed_q <= 1'b0;
    end else begin
      if (load) begin
        mx_q     <= bus.in_mx;
        my_q     <= my_ld;
        signed_q <= bus.in_signed;
      end else if (shift) begin
        my_q <= my_sh;
      end

      if (bus.abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:  if (bus.in_valid) state <= ST_SHIFT;
          ST_SHIFT: if (shift && cnt_last) state <= ST_DONE;
          ST_DONE:  if (bus.out_ack) state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready = (state == ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.mx       = mx_q;
  assign bus.my_digit = my_q[STEP-1:0];
  assign bus.my_last  = (state == ST_SHIFT) && cnt_last;
  assign bus.my_zero  = (my_q == '0);
  assign bus.dig_left = cnt;

endmodule
